// File: rtl/exp_softmax_normalizer.sv
// Softmax normaliser: buffers a vector of unsigned Q.8 exponentials, sums them, then
// streams each element divided by the sum as a Q0.Q_W probability (restoring divider).
module exp_softmax_normalizer #(
    parameter int N_MAX  = 8,
    parameter int DATA_W = 32,
    parameter int Q_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [Q_W-1:0]    out_data,
    output logic              out_last,
    output logic              busy
);

    localparam int PTR_W  = $clog2(N_MAX);
    localparam int CNT_W  = PTR_W + 1;
    localparam int ACC_W  = DATA_W + PTR_W;
    localparam int STEP_W = $clog2(Q_W + 1);

    localparam logic [1:0] ST_COLLECT = 2'd0;
    localparam logic [1:0] ST_DIV     = 2'd1;
    localparam logic [1:0] ST_SEND    = 2'd2;

    logic [1:0]        state_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [ACC_W-1:0]  sum_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic              prime_reg;
    logic [STEP_W-1:0] step_reg;
    logic [ACC_W-1:0]  rem_reg;
    logic [Q_W-1:0]    quo_reg;
    logic              out_valid_reg;
    logic [Q_W-1:0]    out_data_reg;
    logic              out_last_reg;
    logic [DATA_W-1:0] rd_data_reg;

    logic [DATA_W-1:0] buf_mem [N_MAX];

    logic              accept;
    logic              end_of_vec;
    logic [ACC_W-1:0]  sum_next;
    logic [PTR_W-1:0]  wr_addr;
    logic [PTR_W-1:0]  rd_addr;
    logic [ACC_W:0]    trial;
    logic              q_bit;
    logic [ACC_W-1:0]  diff;
    logic [ACC_W-1:0]  rem_next;
    logic [Q_W:0]      quo_full;
    logic [Q_W-1:0]    div_result;
    logic              is_last;

    assign in_ready  = (state_reg == ST_COLLECT);
    assign busy      = (state_reg != ST_COLLECT);
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_last  = out_last_reg;

    assign accept     = in_valid && (state_reg == ST_COLLECT);
    assign end_of_vec = in_last || (count_reg == CNT_W'(N_MAX - 1));
    assign sum_next   = sum_reg + ACC_W'(in_data);
    assign wr_addr    = count_reg[PTR_W-1:0];
    // While waiting in SEND, prefetch the next element so the next DIV can start at once.
    assign rd_addr    = (state_reg == ST_SEND) ? rd_ptr_reg + PTR_W'(1) : rd_ptr_reg;
    assign is_last    = (CNT_W'(rd_ptr_reg) == count_reg - CNT_W'(1));

    // Step 0 compares the raw element (quotient MSB, weight 2^Q_W); later steps shift.
    assign trial      = (step_reg == '0) ? (ACC_W + 1)'(rd_data_reg) : {rem_reg, 1'b0};
    assign q_bit      = (trial >= {1'b0, sum_reg});
    assign diff       = trial[ACC_W-1:0] - sum_reg;
    assign rem_next   = q_bit ? diff : trial[ACC_W-1:0];
    assign quo_full   = {quo_reg, q_bit};
    assign div_result = quo_full[Q_W] ? {Q_W{1'b1}} : quo_full[Q_W-1:0];

    always_ff @(posedge clk) begin
        if (accept) begin
            buf_mem[wr_addr] <= in_data;
        end
        rd_data_reg <= buf_mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_COLLECT;
            count_reg     <= '0;
            sum_reg       <= '0;
            rd_ptr_reg    <= '0;
            prime_reg     <= 1'b0;
            step_reg      <= '0;
            rem_reg       <= '0;
            quo_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_last_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_COLLECT: begin
                    if (accept) begin
                        sum_reg   <= sum_next;
                        count_reg <= count_reg + CNT_W'(1);
                        if (end_of_vec) begin
                            state_reg  <= ST_DIV;
                            rd_ptr_reg <= '0;
                            step_reg   <= '0;
                            prime_reg  <= 1'b1;
                        end
                    end
                end
                ST_DIV: begin
                    if (sum_reg == '0) begin
                        out_data_reg  <= '0;
                        out_last_reg  <= is_last;
                        out_valid_reg <= 1'b1;
                        state_reg     <= ST_SEND;
                    end else if (prime_reg) begin
                        // The last element may have been written on the entry edge; wait one read.
                        prime_reg <= 1'b0;
                    end else begin
                        rem_reg  <= rem_next;
                        quo_reg  <= quo_full[Q_W-1:0];
                        step_reg <= step_reg + STEP_W'(1);
                        if (step_reg == STEP_W'(Q_W)) begin
                            out_data_reg  <= div_result;
                            out_last_reg  <= is_last;
                            out_valid_reg <= 1'b1;
                            state_reg     <= ST_SEND;
                        end
                    end
                end
                ST_SEND: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        if (out_last_reg) begin
                            count_reg <= '0;
                            sum_reg   <= '0;
                            state_reg <= ST_COLLECT;
                        end else begin
                            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                            step_reg   <= '0;
                            state_reg  <= ST_DIV;
                        end
                    end
                end
                default: state_reg <= ST_COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_exp_softmax_normalizer.sv
// Bench for exp_softmax_normalizer: directed scenarios plus random vectors checked
// against an arithmetic model of element*2^16/sum with truncation and saturation.
module tb_exp_softmax_normalizer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;
    logic        busy;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    exp_softmax_normalizer #(.N_MAX(8), .DATA_W(32), .Q_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] ref_q(input longint unsigned e, input longint unsigned s);
        longint unsigned q;
        if (s == 0) return 16'h0000;
        q = (e << 16) / s;
        if (q > 64'd65535) return 16'hFFFF;
        return q[15:0];
    endfunction

    task automatic push(input logic [31:0] d, input logic l, output int acc_cyc);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && n < 300) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL push_timeout: in_ready=%0b required 1", in_ready);
            in_valid = 1'b0;
            acc_cyc = -1;
            return;
        end
        @(posedge clk); #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        in_last  = 1'b0;
        $display("push data=%h last=%0b at cycle %0d", d, l, acc_cyc);
    endtask

    task automatic pop(input int stall, output logic [15:0] d, output logic l,
                       output int v_cyc, output int hs_cyc);
        int n = 0;
        out_ready = 1'b0;
        while (!out_valid && n < 300) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (!out_valid) begin
            errors++;
            $display("FAIL pop_timeout: out_valid=%0b required 1", out_valid);
            d = 16'hxxxx; l = 1'bx; v_cyc = -1000; hs_cyc = -1000;
            return;
        end
        v_cyc = cyc;
        repeat (stall) begin
            @(posedge clk); #1;
        end
        d = out_data;
        l = out_last;
        out_ready = 1'b1;
        @(posedge clk); #1;
        hs_cyc = cyc;
        out_ready = 1'b0;
        $display("pop data=%h last=%0b valid@%0d handshake@%0d", d, l, v_cyc, hs_cyc);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b need 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b need 0", out_valid); end
        checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL reset_out_data: got %h need 0000", out_data); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b need 0", out_last); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b need 0", busy); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_pair();
        int a, v, h, hprev;
        logic [15:0] d; logic l;
        push(32'd256, 1'b0, a);
        push(32'd256, 1'b1, a);
        hprev = a;
        for (int i = 0; i < 2; i++) begin
            pop(0, d, l, v, h);
            checks++; if (d !== 16'h8000) begin errors++; $display("FAIL pair_data[%0d]: got %h need 8000", i, d); end
            checks++; if (l !== (i == 1)) begin errors++; $display("FAIL pair_last[%0d]: got %b need %0b", i, l, i == 1); end
            checks++;
            if (v - hprev !== ((i == 0) ? 18 : 17)) begin
                errors++; $display("FAIL pair_latency[%0d]: got %0d need %0d", i, v - hprev, (i == 0) ? 18 : 17);
            end
            hprev = h;
        end
    endtask

    task automatic test_four_busy();
        int a, v, h;
        logic [15:0] d; logic l;
        for (int i = 0; i < 4; i++) push(32'd256, i == 3, a);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL four_busy_after_accept: got %b need 1", busy); end
        for (int i = 0; i < 4; i++) begin
            pop(i, d, l, v, h);
            checks++; if (d !== 16'h4000) begin errors++; $display("FAIL four_data[%0d]: got %h need 4000", i, d); end
            checks++; if (l !== (i == 3)) begin errors++; $display("FAIL four_last[%0d]: got %b need %0b", i, l, i == 3); end
            checks++;
            if (busy !== (i != 3)) begin errors++; $display("FAIL four_busy[%0d]: got %b need %0b", i, busy, i != 3); end
        end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL four_in_ready_after: got %b need 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL four_out_valid_drop: got %b need 0", out_valid); end
    endtask

    task automatic test_single_sat();
        int a, v, h;
        logic [15:0] d; logic l;
        push(32'd1000, 1'b1, a);
        pop(2, d, l, v, h);
        checks++; if (d !== 16'hFFFF) begin errors++; $display("FAIL sat_data: got %h need ffff", d); end
        checks++; if (l !== 1'b1) begin errors++; $display("FAIL sat_last: got %b need 1", l); end
    endtask

    task automatic test_zero();
        int a, v, h, hprev;
        logic [15:0] d; logic l;
        for (int i = 0; i < 3; i++) push(32'd0, i == 2, a);
        hprev = a;
        for (int i = 0; i < 3; i++) begin
            pop(0, d, l, v, h);
            checks++; if (d !== 16'h0000) begin errors++; $display("FAIL zero_data[%0d]: got %h need 0000", i, d); end
            checks++; if (l !== (i == 2)) begin errors++; $display("FAIL zero_last[%0d]: got %b need %0b", i, l, i == 2); end
            if (i > 0) begin
                checks++;
                if (v - hprev !== 1) begin errors++; $display("FAIL zero_div_cycles[%0d]: got %0d need 1", i, v - hprev); end
            end
            hprev = h;
        end
    endtask

    task automatic test_nine_words();
        int a, v, h;
        logic [15:0] d; logic l;
        for (int i = 0; i < 8; i++) push(32'd256, 1'b0, a);
        in_valid = 1'b1; in_data = 32'd256; in_last = 1'b1;
        for (int i = 0; i < 8; i++) begin
            pop(0, d, l, v, h);
            checks++; if (d !== 16'h2000) begin errors++; $display("FAIL nine_data[%0d]: got %h need 2000", i, d); end
            checks++; if (l !== (i == 7)) begin errors++; $display("FAIL nine_last[%0d]: got %b need %0b", i, l, i == 7); end
            checks++;
            if (in_ready !== (i == 7)) begin errors++; $display("FAIL nine_in_ready[%0d]: got %b need %0b", i, in_ready, i == 7); end
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL nine_ninth_accept: busy got %b need 1", busy); end
        pop(1, d, l, v, h);
        checks++; if (d !== 16'hFFFF) begin errors++; $display("FAIL nine_ninth_data: got %h need ffff", d); end
        checks++; if (l !== 1'b1) begin errors++; $display("FAIL nine_ninth_last: got %b need 1", l); end
    endtask

    task automatic test_backpressure_reset();
        int a, v, h, n;
        logic [15:0] d; logic l;
        logic seen;
        push(32'd256, 1'b0, a);
        push(32'd256, 1'b0, a);
        push(32'd512, 1'b1, a);
        out_ready = 1'b0;
        n = 0;
        while (!out_valid && n < 300) begin
            @(posedge clk); #1; n++;
        end
        checks++; if (out_data !== 16'h4000) begin errors++; $display("FAIL bp_first_data: got %h need 4000", out_data); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== 16'h4000 || out_last !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got valid=%b data=%h last=%b need 1/4000/0", i, out_valid, out_data, out_last);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        $display("pop data=4000 after backpressure at cycle %0d", cyc);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b need 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b need 1", in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b need 0", busy); end
        seen = 1'b0;
        repeat (25) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_partial_output: got out_valid seen=%b need 0", seen); end
        push(32'd256, 1'b0, a);
        push(32'd256, 1'b1, a);
        for (int i = 0; i < 2; i++) begin
            pop(0, d, l, v, h);
            checks++; if (d !== 16'h8000) begin errors++; $display("FAIL rst_new_data[%0d]: got %h need 8000", i, d); end
            checks++; if (l !== (i == 1)) begin errors++; $display("FAIL rst_new_last[%0d]: got %b need %0b", i, l, i == 1); end
        end
    endtask

    task automatic test_random();
        int a, v, h, len;
        logic use_last;
        logic [31:0] vals [8];
        longint unsigned s;
        logic [15:0] d, exp_d; logic l;
        for (int vec = 0; vec < 15; vec++) begin
            len = $urandom_range(1, 8);
            use_last = (len < 8) ? 1'b1 : 1'($urandom % 2);
            s = 0;
            for (int i = 0; i < len; i++) begin
                case ($urandom % 4)
                    0: vals[i] = $urandom;
                    1: vals[i] = $urandom_range(0, 1000);
                    2: vals[i] = 32'd0;
                    default: vals[i] = $urandom >> ($urandom % 32);
                endcase
                s += longint'(vals[i]);
            end
            for (int i = 0; i < len; i++) push(vals[i], use_last && (i == len - 1), a);
            for (int i = 0; i < len; i++) begin
                pop($urandom_range(0, 3), d, l, v, h);
                exp_d = ref_q(longint'(vals[i]), s);
                checks++;
                if (d !== exp_d) begin
                    errors++; $display("FAIL rand_data[v%0d e%0d]: got %h need %h (elem %h sum %0d)", vec, i, d, exp_d, vals[i], s);
                end
                checks++;
                if (l !== (i == len - 1)) begin
                    errors++; $display("FAIL rand_last[v%0d e%0d]: got %b need %0b", vec, i, l, i == len - 1);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_pair();
        test_four_busy();
        test_single_sat();
        test_zero();
        test_nine_words();
        test_backpressure_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
